// File: rtl/axi_rd_responder.sv
// rtl/axi_rd_responder.sv - AXI4 read responder returning beat byte addresses as data (option: AXI_RD_RESP_STALL_EN)
module axi_rd_responder #(
    parameter int ADDR_BITS       = 64,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 64,
    parameter int LOG_REQ_DEPTH   = 2,
    parameter int LATENCY_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       en,
    input  logic                       s_ar_valid,
    output logic                       s_ar_ready,
    input  logic [ADDR_BITS-1:0]       s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
    input  logic [TID_WIDTH-1:0]       s_ar_id,
    output logic                       s_r_valid,
    input  logic                       s_r_ready,
    output logic [TID_WIDTH-1:0]       s_r_id,
    output logic [DATA_WIDTH-1:0]      s_r_data,
    output logic                       s_r_last,
    input  logic [LATENCY_WIDTH-1:0]   crs_latency,
    output logic [LOG_REQ_DEPTH:0]     outstandingCnt,
    output logic                       busy
);

    localparam int DEPTH = 1 << LOG_REQ_DEPTH;
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_t;

    state_t                     state, state_next;
    logic [ADDR_BITS-1:0]       q_addr [DEPTH];
    logic [BURST_LEN_WIDTH-1:0] q_len  [DEPTH];
    logic [TID_WIDTH-1:0]       q_id   [DEPTH];
    logic [LOG_REQ_DEPTH-1:0]   wr_ptr, rd_ptr;
    logic [LOG_REQ_DEPTH:0]     cnt_next;
    logic [LATENCY_WIDTH-1:0]   lat_cnt;
    logic [BURST_LEN_WIDTH-1:0] beat_cnt;
    logic                       rst_done;
    logic                       push, pop, in_burst, beat_last;
    logic [ADDR_BITS-1:0]       beat_addr;

    // rst_done keeps s_ar_ready low while reset is asserted even though the count reads zero
    assign s_ar_ready = en && rst_done &&
                        (outstandingCnt < (LOG_REQ_DEPTH+1)'(DEPTH));
    assign push       = s_ar_valid && s_ar_ready;
    assign pop        = s_r_valid && s_r_ready && s_r_last;
    assign in_burst   = (state == ST_BURST);
    assign beat_last  = (beat_cnt == q_len[rd_ptr]);
    assign beat_addr  = q_addr[rd_ptr] + ADDR_BITS'(beat_cnt) * ADDR_BITS'(BYTES);

    always_comb begin
        cnt_next = outstandingCnt;
        if (push && !pop)
            cnt_next = outstandingCnt + 1'b1;
        else if (pop && !push)
            cnt_next = outstandingCnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= s_ar_addr;
            q_len[wr_ptr]  <= s_ar_len;
            q_id[wr_ptr]   <= s_ar_id;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rst_done       <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            outstandingCnt <= '0;
        end else begin
            rst_done       <= 1'b1;
            outstandingCnt <= cnt_next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (outstandingCnt != '0) state_next = ST_WAIT;
            ST_WAIT:  if (lat_cnt == '0) state_next = ST_BURST;
            ST_BURST: if (pop) state_next = (cnt_next != '0) ? ST_WAIT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Latency is sampled only on entry to ST_WAIT; later changes to crs_latency are ignored
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lat_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            if (state_next == ST_WAIT && state != ST_WAIT)
                lat_cnt <= crs_latency;
            else if (state == ST_WAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;
            if (state == ST_WAIT)
                beat_cnt <= '0;
            else if (s_r_valid && s_r_ready && !s_r_last)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

`ifdef AXI_RD_RESP_STALL_EN
    logic [7:0] lfsr;
    logic       valid_hold;

    // valid_hold keeps a presented beat up until it is taken, whatever the LFSR does
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr       <= 8'hA5;
            valid_hold <= 1'b0;
        end else begin
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            valid_hold <= s_r_valid && !s_r_ready;
        end
    end

    always_comb begin
        s_r_valid = in_burst && (valid_hold || lfsr[0]);
    end
`else
    always_comb begin
        s_r_valid = in_burst;
    end
`endif

    always_comb begin
        s_r_id   = '0;
        s_r_data = '0;
        s_r_last = 1'b0;
        busy     = (state != ST_IDLE);
        if (in_burst) begin
            s_r_id   = q_id[rd_ptr];
            s_r_data = DATA_WIDTH'(beat_addr);
            s_r_last = beat_last;
        end
    end

endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
DDR-side AXI4 read-channel responder: the subordinate end of the prefetcher controller's master AR/R ports.
- Accepts AR requests into an in-order request queue and waits a programmable per-request latency.
- Returns each burst as len+1 R beats tagged with the request ID.
- Beat data is the beat's byte address, so benches can check prefetched data end-to-end.
- Used as the memory model in prefetcher and system benches, and as a DDR stub in FPGA bring-up.

Parameters:
ADDR_BITS, 64, address width
BURST_LEN_WIDTH, 8, AR len width (AXI len = beats-1)
TID_WIDTH, 8, transaction ID width
DATA_WIDTH, 64, R data width; bytes per beat = DATA_WIDTH/8
LOG_REQ_DEPTH, 2, request queue holds 2^LOG_REQ_DEPTH requests
LATENCY_WIDTH, 8, width of latency CR

Ports:
clk  in  1  clock
resetN  in  1  asynchronous active-low reset
en  in  1  enables AR acceptance
s_ar_valid  in  1  AR valid
s_ar_ready  out  1  AR ready
s_ar_addr  in  ADDR_BITS  burst start byte address
s_ar_len  in  BURST_LEN_WIDTH  beats-1
s_ar_id  in  TID_WIDTH  transaction ID
s_r_valid  out  1  R valid
s_r_ready  in  1  R ready
s_r_id  out  TID_WIDTH  ID of current burst
s_r_data  out  DATA_WIDTH  beat data
s_r_last  out  1  last beat of burst
crs_latency  in  LATENCY_WIDTH  idle cycles between start of service and first beat
outstandingCnt  out  LOG_REQ_DEPTH+1  queued requests, including the one in service
busy  out  1  FSM not in ST_IDLE

Behaviour:
- Reset (async, resetN=0): queue empty; FSM ST_IDLE; outstandingCnt=0; s_ar_ready=0, s_r_valid=0, s_r_last=0, s_r_id=0, s_r_data=0, busy=0. Applies mid-burst: the in-flight burst is dropped with no further beats.
- AR acceptance:
  - s_ar_ready = en && (outstandingCnt < 2^LOG_REQ_DEPTH), decoded from registered state only.
  - Push {addr,len,id} on s_ar_valid && s_ar_ready.
  - A pop in the same cycle does not make room until the next cycle.
  - en=0 blocks acceptance only; queued and in-flight requests complete.
- outstandingCnt: +1 on push, -1 on final-beat handshake, unchanged on simultaneous push and pop.
- FSM states ST_IDLE, ST_WAIT, ST_BURST; it serves the queue head, strictly in order.
  - ST_IDLE: if the queue is non-empty, load latCnt=crs_latency and go to ST_WAIT; otherwise stay. A push into an empty queue is seen by the FSM the cycle after the push.
  - ST_WAIT: if latCnt==0 go to ST_BURST with beatCnt=0; else decrement. First beat valid = crs_latency+1 cycles after leaving ST_IDLE.
  - ST_BURST: s_r_valid per the Optional Feature.
    - s_r_id = head id.
    - s_r_data = (head addr + beatCnt*(DATA_WIDTH/8)), truncated or zero-extended to DATA_WIDTH; address arithmetic wraps mod 2^ADDR_BITS.
    - s_r_last = (beatCnt == head len).
    - On handshake with !last: beatCnt++.
    - On handshake with last: pop; if more entries remain, reload latCnt=crs_latency and go to ST_WAIT; else go to ST_IDLE.
- AXI rules:
  - Once s_r_valid=1, s_r_valid, id, data and last stay stable until s_r_ready.
  - s_r_valid=0 outside ST_BURST.
  - len=0 is a single beat with last=1.
  - len=255 is 256 beats; beatCnt is BURST_LEN_WIDTH bits and never wraps.
- crs_latency is sampled only when latCnt is loaded; changes mid-wait have no effect.

Optional Feature:
- Macro: AXI_RD_RESP_STALL_EN.
- Defined:
  - 8-bit LFSR, seed 8'hA5 at reset, taps x^8+x^6+x^5+x^4+1, advances every cycle.
  - In ST_BURST with s_r_valid=0, s_r_valid rises only in a cycle where lfsr[0]==1.
  - Once high it holds until the handshake, so random inter-beat gaps never violate AXI.
- Undefined: no LFSR; s_r_valid=1 in every ST_BURST cycle.

Test Plan:
1. Reset with s_ar_valid=1 -> all outputs 0; after release with en=1, s_ar_ready=1 and outstandingCnt=0.
2. crs_latency=3; single AR addr=64'hdeadbeef, len=0, id=3; s_r_ready=1 -> one beat, data=64'hdeadbeef, id=3, last=1, valid 4 cycles after leaving ST_IDLE; outstandingCnt 1->0.
3. AR addr=64'h1000, len=3, id=5; s_r_ready toggled 1,0,1,... -> beats 64'h1000, 64'h1008, 64'h1010, 64'h1018 with last only on the 4th; outputs stable while ready=0.
4. Push 5 ARs back-to-back (ids 1..5, depth 4), s_r_ready=0 -> s_ar_ready=0 after 4, outstandingCnt=4; the 5th is accepted only the cycle after the first burst's last handshake; R ids arrive in order 1..5.
5. en=0 during a len=7 burst -> s_ar_ready=0, all 8 beats still delivered; resetN=0 at beat 3 -> s_r_valid=0 immediately, queue empty, no further beats.
6. With AXI_RD_RESP_STALL_EN, s_r_ready=1, len=15 -> 16 beats with correct data and gaps, valid never drops without a handshake; without the macro -> 16 consecutive beats, no gaps.
